// File: rtl/pb_debounce_pkg.sv
// Shared defaults and width helpers for the multi-channel push-button debouncer.
// Enable the long-press detector by defining PB_LONG_PRESS_EN.
package pb_debounce_pkg;

    localparam int N_CH_DEF       = 4;
    localparam int TICK_DIV_DEF   = 250;
    localparam int STABLE_CNT_DEF = 3;
    localparam int LONG_TICKS_DEF = 1000;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int ctr_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int TICK_W_DEF = ctr_w(TICK_DIV_DEF - 1);
    localparam int CNT_W_DEF  = ctr_w(STABLE_CNT_DEF);
    localparam int HOLD_W_DEF = ctr_w(LONG_TICKS_DEF);

endpackage

// File: rtl/pb_debounce_chan.sv
// One debounce channel: 2-FF synchroniser, tick-qualified level, rise/fall pulses,
// and (with PB_LONG_PRESS_EN) a saturating hold counter producing pb_long.
//   clk, rst (sync, active-high), tick (shared sample enable), pb_in (raw async)
//   pb_level, pb_rise, pb_fall, pb_long (all registered)
module pb_debounce_chan
    import pb_debounce_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF
`ifdef PB_LONG_PRESS_EN
    ,
    parameter int LONG_TICKS = LONG_TICKS_DEF
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pb_in,
    output logic pb_level,
    output logic pb_rise,
    output logic pb_fall,
    output logic pb_long
);

    localparam int CW = ctr_w(STABLE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Synchroniser runs every clk so the tick only picks the sample instant.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pb_in;
            s2 <= s1;
        end
    end

    // Any sample agreeing with the current level restarts qualification,
    // so a glitch shorter than STABLE_CNT ticks never changes the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pb_level <= 1'b0;
            pb_rise  <= 1'b0;
            pb_fall  <= 1'b0;
        end else begin
            pb_rise <= 1'b0;
            pb_fall <= 1'b0;
            if (tick) begin
                if (s2 == pb_level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt      <= '0;
                    pb_level <= s2;
                    pb_rise  <= s2;
                    pb_fall  <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef PB_LONG_PRESS_EN
    localparam int HW = ctr_w(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    logic [HW-1:0] hold;

    // Saturation at HOLD_MAX is what limits pb_long to one pulse per press;
    // dropping pb_level clears the counter and re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold    <= '0;
            pb_long <= 1'b0;
        end else begin
            pb_long <= 1'b0;
            if (!pb_level) begin
                hold <= '0;
            end else if (tick && hold != HOLD_MAX) begin
                hold    <= hold + 1'b1;
                pb_long <= (hold == HOLD_MAX - 1'b1);
            end
        end
    end
`else
    assign pb_long = 1'b0;
`endif

endmodule

// File: rtl/pb_debounce_multi.sv
// N-channel push-button debouncer in a single clock domain, sampled by a shared tick.
// Ports: clk, rst (sync, active-high), pb_in[N_CH], pb_level/pb_rise/pb_fall/pb_long[N_CH].
// Long-press pulses exist only when PB_LONG_PRESS_EN is defined; otherwise pb_long is 0.
module pb_debounce_multi
    import pb_debounce_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF
`ifdef PB_LONG_PRESS_EN
    ,
    parameter int LONG_TICKS = LONG_TICKS_DEF
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] pb_rise,
    output logic [N_CH-1:0] pb_fall,
    output logic [N_CH-1:0] pb_long
);

    localparam int TW = ctr_w(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    // Tick is high during the last count, so the first one after reset
    // falls on clk cycle TICK_DIV.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pb_debounce_chan #(
            .STABLE_CNT(STABLE_CNT)
`ifdef PB_LONG_PRESS_EN
            ,
            .LONG_TICKS(LONG_TICKS)
`endif
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .pb_in   (pb_in[g]),
            .pb_level(pb_level[g]),
            .pb_rise (pb_rise[g]),
            .pb_fall (pb_fall[g]),
            .pb_long (pb_long[g])
        );
    end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Self-checking bench for pb_debounce_multi: directed stimulus, a queue-based
// reference model compared every cycle, and hand-computed timing expectations.
module tb_pb_debounce_multi;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int LT = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] pb_in = '0;
    logic [N-1:0] pb_level;
    logic [N-1:0] pb_rise;
    logic [N-1:0] pb_fall;
    logic [N-1:0] pb_long;

    always #5 clk = ~clk;

    pb_debounce_multi #(
        .N_CH      (N),
        .TICK_DIV  (TD),
        .STABLE_CNT(SC)
`ifdef PB_LONG_PRESS_EN
        ,
        .LONG_TICKS(LT)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pb_in   (pb_in),
        .pb_level(pb_level),
        .pb_rise (pb_rise),
        .pb_fall (pb_fall),
        .pb_long (pb_long)
    );

    int checks   = 0;
    int failures = 0;
    int nprint   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (nprint < 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
            nprint++;
        end
    endtask

    // Reference model: s2 is pb_in from two edges ago; the level flips once
    // the last SC tick samples all disagree with it; pb_long fires LT ticks
    // after the tick that raised the level.
    bit           started = 0;
    int           n_edge;
    int           tick_no;
    int           rise_tick[N];
    logic [N-1:0] pin_q[$];
    bit           tq[N][$];
    logic [N-1:0] e_level, e_rise, e_fall, e_long;

    task automatic model_step();
        logic [N-1:0] samp;
        logic [N-1:0] old;
        bit           all_diff;
        if (rst) begin
            started = 1;
            n_edge  = 0;
            tick_no = 0;
            pin_q.delete();
            pin_q.push_back('0);
            pin_q.push_back('0);
            for (int c = 0; c < N; c++) begin
                tq[c].delete();
                rise_tick[c] = 0;
            end
            e_level = '0;
            e_rise  = '0;
            e_fall  = '0;
            e_long  = '0;
        end else begin
            samp = pin_q[pin_q.size() - 2];
            pin_q.push_back(pb_in);
            if (pin_q.size() > 4) void'(pin_q.pop_front());
            n_edge++;
            e_rise = '0;
            e_fall = '0;
            e_long = '0;
            if (n_edge % TD == 0) begin
                tick_no++;
                old = e_level;
                for (int c = 0; c < N; c++) begin
                    tq[c].push_back(samp[c]);
                    if (tq[c].size() > SC) void'(tq[c].pop_front());
`ifdef PB_LONG_PRESS_EN
                    if (old[c] && tick_no == rise_tick[c] + LT)
                        e_long[c] = 1'b1;
`endif
                    all_diff = (tq[c].size() == SC);
                    foreach (tq[c][k])
                        if (tq[c][k] == old[c]) all_diff = 0;
                    if (all_diff) begin
                        e_level[c] = samp[c];
                        if (samp[c]) begin
                            e_rise[c]    = 1'b1;
                            rise_tick[c] = tick_no;
                        end else begin
                            e_fall[c] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (started) begin
                chk("model_level", pb_level, e_level);
                chk("model_rise",  pb_rise,  e_rise);
                chk("model_fall",  pb_fall,  e_fall);
                chk("model_long",  pb_long,  e_long);
            end
        end
    end

    // Waits for a pulse on one channel; lat = negedges waited, -1 on timeout.
    // kind: 0 rise, 1 fall, 2 long.
    task automatic wait_pulse(input int ch, input int kind, input int limit,
                              output int lat);
        logic v;
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            v = (kind == 0) ? pb_rise[ch] :
                (kind == 1) ? pb_fall[ch] : pb_long[ch];
            if (v === 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r;
        int f;
        int l;

        step(3);
        rst = 1'b0;
        step(2);
        chk("reset_outputs", {pb_level, pb_rise, pb_fall, pb_long}, 16'h0000);

        // 1: single press on channel 0
        pb_in[0] = 1'b1;
        wait_pulse(0, 0, 30, lat);
        chk("t1_rise_latency_11_14", (lat >= 11 && lat <= 14), 1);
        step(5);
        chk("t1_level_only_ch0", pb_level, 4'b0001);

        // 2: bouncing channel 1, then held high
        r = 0;
        f = 0;
        for (int i = 0; i < 20; i++) begin
            pb_in[1] = ~pb_in[1];
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                r += int'(pb_rise[1]);
                f += int'(pb_fall[1]);
            end
        end
        pb_in[1] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            r += int'(pb_rise[1]);
            f += int'(pb_fall[1]);
        end
        chk("t2_rise_count", r, 1);
        chk("t2_fall_count", f, 0);
        chk("t2_level_ch1", pb_level[1], 1'b1);

        // 3: short dropout on a high channel is rejected
        pb_in[2] = 1'b1;
        pb_in[3] = 1'b1;
        step(20);
        chk("t3_all_high", pb_level, 4'hF);
        pb_in[2] = 1'b0;
        r = 0;
        f = 0;
        for (int k = 0; k < 36; k++) begin
            if (k == 6) pb_in[2] = 1'b1;
            @(negedge clk);
            r += int'(pb_rise[2]);
            f += int'(pb_fall[2]);
        end
        chk("t3_no_pulses", r + f, 0);
        chk("t3_level_ch2", pb_level[2], 1'b1);

        // 4: simultaneous rise on ch0 and fall on ch3
        pb_in[0] = 1'b0;
        wait_pulse(0, 1, 30, lat);
        chk("t4_ch0_released", (lat > 0), 1);
        step(3);
        pb_in[0] = 1'b1;
        pb_in[3] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            @(negedge clk);
            if (pb_rise[0] === 1'b1 || pb_fall[3] === 1'b1) begin
                lat = i;
                chk("t4_same_cycle", {pb_rise[0], pb_fall[3]}, 2'b11);
            end
        end
        chk("t4_latency_11_14", (lat >= 11 && lat <= 14), 1);

        // 5: reset mid-qualification
        pb_in = 4'h0;
        step(20);
        chk("t5_all_low", pb_level, 4'h0);
        pb_in = 4'hF;
        step(6);
        rst = 1'b1;
        step(1);
        chk("t5_reset_clears", {pb_level, pb_rise, pb_fall, pb_long}, 16'h0000);
        rst = 1'b0;
        wait_pulse(0, 0, 30, lat);
        chk("t5_rise_latency", lat, 12);
        chk("t5_rise_all", pb_rise, 4'hF);

        // 6: long press
`ifdef PB_LONG_PRESS_EN
        wait_pulse(0, 2, 60, lat);
        chk("t6_long_latency", lat, 40);
        chk("t6_long_all", pb_long, 4'hF);
        l = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            l += int'(pb_long[0]);
        end
        chk("t6_no_repeat", l, 0);
        pb_in[0] = 1'b0;
        step(20);
        pb_in[0] = 1'b1;
        wait_pulse(0, 0, 30, lat);
        chk("t6_repress_rise", (lat > 0), 1);
        wait_pulse(0, 2, 60, lat);
        chk("t6_rearm_latency", lat, 40);
`else
        l = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            l += (pb_long != 4'h0) ? 1 : 0;
        end
        chk("t6_long_disabled", l, 0);
        chk("t6_level_held", pb_level, 4'hF);
`endif

        step(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
